pokey_timer_sequencer: RTL and testbench
========================================

// Module: pokey_timer_sequencer
// PURPOSE
//  Controls the four pokey_countdown_timer instances in one POKEY.
//  - Holds the AUDF reload values written by the CPU.
//  - Selects each timer's clock strobe from AUDCTL.
//  - Chains timer pairs into 16-bit counters.
//  - Issues reloads on underflow and on STIMER.
//  Sits between the POKEY register decode and the timer datapath.
// PARAMETERS
//  (none)
// PORTS
//  clk           in   1   system clock
//  reset_n       in   1   asynchronous, active-low reset
//  enable_179    in   1   1.79 MHz strobe (1 clk wide)
//  enable_64     in   1   64 kHz strobe
//  enable_15     in   1   15 kHz strobe
//  cpu_wr        in   1   register write strobe
//  cpu_addr      in   4   register address
//  cpu_data      in   8   write data
//  underflow     in   4   underflow pulses from timers 0..3 (after their delay line)
//  timer_enable  out  4   per-timer enable (to timer "enable" and "enable_underflow")
//  timer_wr_en   out  4   per-timer load strobe
//  timer_data    out  32  load values; timer i uses bits [8i+7:8i]
//  audctl        out  8   current AUDCTL, for the channel logic
// BEHAVIOUR
//  Register writes:
//  - Address map: 0/2/4/6 = AUDF1..4 shadow regs; 8 = AUDCTL; 9 = STIMER (data ignored).
//  - All other addresses are ignored here.
//  - Writes land at the clk edge with cpu_wr=1.
//  - An AUDF write changes only the shadow reg. The timer sees the new value at its next reload.
//  Reset:
//  - AUDF0..3, audctl, timer_wr_en, timer_data and the run flag all reset to 0.
//  - timer_enable is forced to 0 until run=1.
//  - run is set on the first clk edge after reset_n deasserts.
//  Base clock: base = audctl[0] ? enable_15 : enable_64.
//  timer_enable (combinational, gated by run):
//  - t0 = audctl[6] ? enable_179 : base
//  - t2 = audctl[5] ? enable_179 : base
//  - t1 = audctl[4] ? underflow[0] : base
//  - t3 = audctl[3] ? underflow[2] : base
//  Reload, registered with 1 clk latency:
//  - An underflow[i] high in cycle N gives timer_wr_en[i]=1 in cycle N+1 for exactly 1 clk.
//  - timer_data[i] = AUDF(i) as sampled in cycle N.
//  Joined pairs (audctl[4] for 0/1, audctl[3] for 2/3):
//  - Low-timer underflow does NOT reload the low timer. It wraps 00->FF and clocks the high timer.
//  - High-timer underflow reloads both low and high in the same cycle.
//  - The result is a 16-bit count of {AUDF_hi, AUDF_lo}.
//  STIMER:
//  - Write in cycle N gives timer_wr_en=4'b1111 in cycle N+1.
//  - timer_data = all four AUDF values as of the end of cycle N.
//  Simultaneous events:
//  - STIMER and any underflow in the same cycle: single merged strobe, one load per timer.
//  - AUDF write and the reload-triggering event in the same cycle: the OLD AUDF value loads.
//  - AUDCTL write: takes effect from cycle N+1. It forces no reload, and in-flight reloads complete.
//  Reset asserted mid-operation: all state clears immediately; no pending reload survives.
//  Strobes: enable_* are assumed 1-clk pulses. Coincident 179/64/15 strobes need no special handling.
// CONFIGURATION
//  POKEY_TIMER_IRQ_EN defined:
//  - Adds register address E = IRQEN (8 bit, reset 0).
//  - Adds outputs irq_n (1) and irq_pending (3).
//  - Sources: irq_pending bit0 = timer0, bit1 = timer1, bit2 = timer3.
//  - A pending bit sets 1 clk after an underflow of its source, when the matching IRQEN bit
//    (IRQEN[0], [1], [2]) is 1.
//  - Writing 0 to an IRQEN bit clears its pending bit in the next cycle.
//  - Set and clear in the same cycle: clear wins.
//  - irq_n = ~|irq_pending, registered; reset value 1.
//  POKEY_TIMER_IRQ_EN undefined: no IRQ logic, IRQ ports absent, address E ignored.
// TESTING
//  1. Assert reset_n=0 mid-run -> all outputs 0 and audctl=00. First clk after release: timer_enable still 0.
//  2. AUDF1=05, AUDF3=10, then STIMER -> next clk: timer_wr_en=1111, timer_data[7:0]=05, [23:16]=10.
//  3. audctl=00, AUDF3=10, underflow=0100 -> next clk: timer_wr_en=0100, timer_data[23:16]=10.
//  4. audctl=10, underflow[0] -> timer_enable[1]=1 same cycle, no wr_en[0]. Then underflow[1] -> timer_wr_en=0011.
//  5. audctl=41 -> timer_enable[0] tracks enable_179, timer_enable[2] tracks enable_15,
//     timer_enable[1]/[3] ignore enable_64.
//  6. (POKEY_TIMER_IRQ_EN) IRQEN=01, underflow[0] -> irq_pending=001 and irq_n=0 within 2 clk.
//     Then IRQEN=00 -> irq_n=1.

Source files
------------

// File: rtl/pokey_timer_sequencer.sv
// POKEY timer sequencer: AUDF shadow registers, AUDCTL clock selection, pair joining and reloads.
// Optional IRQ logic (IRQEN register, irq_n, irq_pending) is enabled by defining POKEY_TIMER_IRQ_EN.
module pokey_timer_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_179,
    input  logic        enable_64,
    input  logic        enable_15,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic [3:0]  underflow,
    output logic [3:0]  timer_enable,
    output logic [3:0]  timer_wr_en,
    output logic [31:0] timer_data,
`ifdef POKEY_TIMER_IRQ_EN
    output logic        irq_n,
    output logic [2:0]  irq_pending,
`endif
    output logic [7:0]  audctl
);

    logic [3:0][7:0] audf_q;
    logic [7:0]      audctl_q;
    logic            run_q;
    logic [3:0]      wr_en_q, wr_en_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      wr_audf;
    logic            wr_audctl, wr_stimer;
    logic            base;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_audf[i] = cpu_wr && (cpu_addr == 4'(2 * i));
        end
        wr_audctl = cpu_wr && (cpu_addr == 4'h8);
        wr_stimer = cpu_wr && (cpu_addr == 4'h9);
    end

    always_comb begin
        base            = audctl_q[0] ? enable_15 : enable_64;
        timer_enable[0] = audctl_q[6] ? enable_179   : base;
        timer_enable[1] = audctl_q[4] ? underflow[0] : base;
        timer_enable[2] = audctl_q[5] ? enable_179   : base;
        timer_enable[3] = audctl_q[3] ? underflow[2] : base;
        if (!run_q) begin
            timer_enable = 4'b0000;
        end
    end

    // In a joined pair only the high timer's underflow reloads, and it reloads both halves.
    always_comb begin
        wr_en_d = underflow;
        if (audctl_q[4]) begin
            wr_en_d[1:0] = {2{underflow[1]}};
        end
        if (audctl_q[3]) begin
            wr_en_d[3:2] = {2{underflow[3]}};
        end
        if (wr_stimer) begin
            wr_en_d = 4'b1111;
        end
        data_d = data_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_en_d[i]) begin
                data_d[8*i +: 8] = audf_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audf_q   <= '0;
            audctl_q <= 8'h00;
            run_q    <= 1'b0;
            wr_en_q  <= 4'b0000;
            data_q   <= 32'h0;
        end else begin
            run_q   <= 1'b1;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            for (int i = 0; i < 4; i++) begin
                if (wr_audf[i]) begin
                    audf_q[i] <= cpu_data;
                end
            end
            if (wr_audctl) begin
                audctl_q <= cpu_data;
            end
        end
    end

    assign timer_wr_en = wr_en_q;
    assign timer_data  = data_q;
    assign audctl      = audctl_q;

`ifdef POKEY_TIMER_IRQ_EN
    logic [7:0] irqen_q;
    logic [2:0] pending_q, pending_d;
    logic       irq_n_q;
    logic       wr_irqen;
    logic [2:0] irq_clr;

    // Clear is applied after set so a same-cycle clear wins.
    always_comb begin
        wr_irqen  = cpu_wr && (cpu_addr == 4'hE);
        irq_clr   = wr_irqen ? ~cpu_data[2:0] : 3'b000;
        pending_d = (pending_q | ({underflow[3], underflow[1], underflow[0]} & irqen_q[2:0]))
                    & ~irq_clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqen_q   <= 8'h00;
            pending_q <= 3'b000;
            irq_n_q   <= 1'b1;
        end else begin
            pending_q <= pending_d;
            irq_n_q   <= ~|pending_d;
            if (wr_irqen) begin
                irqen_q <= cpu_data;
            end
        end
    end

    assign irq_pending = pending_q;
    assign irq_n       = irq_n_q;
`endif

endmodule

// File: tb/tb_pokey_timer_sequencer.sv
// Scoreboard bench for pokey_timer_sequencer: stimulus queues expected reloads, a monitor checks them.
module tb_pokey_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable_179, enable_64, enable_15;
    logic        cpu_wr;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic [3:0]  underflow;
    logic [3:0]  timer_enable, timer_wr_en;
    logic [31:0] timer_data;
    logic [7:0]  audctl;
`ifdef POKEY_TIMER_IRQ_EN
    logic        irq_n;
    logic [2:0]  irq_pending;
`endif

    typedef struct packed {
        logic [3:0]  wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    pokey_timer_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_179   (enable_179),
        .enable_64    (enable_64),
        .enable_15    (enable_15),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .underflow    (underflow),
        .timer_enable (timer_enable),
        .timer_wr_en  (timer_wr_en),
        .timer_data   (timer_data),
`ifdef POKEY_TIMER_IRQ_EN
        .irq_n        (irq_n),
        .irq_pending  (irq_pending),
`endif
        .audctl       (audctl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_data = d;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic uf(input logic [3:0] v);
        underflow = v;
        tick();
        underflow = 4'b0000;
    endtask

    task automatic expect_load(input logic [3:0] m, input logic [31:0] d);
        exp_t e;
        e.wr = m;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every nonzero load strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && timer_wr_en !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got wr_en=%b data=%h, expected no load",
                         timer_wr_en, timer_data);
            end else begin
                exp_t e;
                logic [31:0] m;
                e = exp_q.pop_front();
                m = {{8{e.wr[3]}}, {8{e.wr[2]}}, {8{e.wr[1]}}, {8{e.wr[0]}}};
                chk("load_wr_en", {28'h0, timer_wr_en}, {28'h0, e.wr});
                chk("load_data", timer_data & m, e.data & m);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        enable_179 = 1'b0; enable_64 = 1'b1; enable_15 = 1'b0;
        cpu_wr = 1'b0; cpu_addr = 4'h0; cpu_data = 8'h00; underflow = 4'b0000;
        #12;
        chk("reset_wr_en", {28'h0, timer_wr_en}, 32'h0);
        chk("reset_data", timer_data, 32'h0);
        chk("reset_audctl", {24'h0, audctl}, 32'h0);
        chk("reset_enable", {28'h0, timer_enable}, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("pre_run_enable", {28'h0, timer_enable}, 32'h0);
        tick();
        chk("run_enable_64", {28'h0, timer_enable}, 32'hF);
        enable_64 = 1'b0;

        // STIMER loads all four shadow registers
        wr(4'h0, 8'h05); wr(4'h2, 8'h22); wr(4'h4, 8'h10); wr(4'h6, 8'h44);
        expect_load(4'b1111, 32'h4410_2205);
        wr(4'h9, 8'hAA);
        tick();

        // Independent timer 2 underflow
        expect_load(4'b0100, 32'h0010_0000);
        uf(4'b0100);
        tick();

        // Joined 0/1: low underflow clocks high timer, no reload
        wr(4'h8, 8'h10);
        underflow = 4'b0001;
        #2;
        chk("joined_low_clocks_high", {28'h0, timer_enable}, 32'h2);
        tick();
        underflow = 4'b0000;
        // High underflow reloads both; concurrent AUDF1 write loads the old value
        expect_load(4'b0011, 32'h0000_2205);
        underflow = 4'b0010;
        cpu_wr = 1'b1; cpu_addr = 4'h0; cpu_data = 8'h77;
        tick();
        underflow = 4'b0000; cpu_wr = 1'b0;
        tick();

        // STIMER merged with an underflow: single strobe
        wr(4'h8, 8'h00);
        expect_load(4'b1111, 32'h4410_2277);
        underflow = 4'b0100;
        cpu_wr = 1'b1; cpu_addr = 4'h9; cpu_data = 8'h00;
        tick();
        underflow = 4'b0000; cpu_wr = 1'b0;
        tick();

        // Clock selection with audctl=41
        wr(4'h8, 8'h41);
        chk("audctl_out", {24'h0, audctl}, 32'h41);
        enable_179 = 1'b1; #2;
        chk("sel_179", {28'h0, timer_enable}, 32'h1);
        enable_179 = 1'b0; enable_64 = 1'b1; #2;
        chk("sel_64_ignored", {28'h0, timer_enable}, 32'h0);
        enable_64 = 1'b0; enable_15 = 1'b1; #2;
        chk("sel_15", {28'h0, timer_enable}, 32'hE);
        enable_15 = 1'b0;
        tick();

        // Joined 2/3
        wr(4'h8, 8'h08);
        underflow = 4'b0100;
        #2;
        chk("joined23_low_clocks_high", {28'h0, timer_enable}, 32'h8);
        tick();
        underflow = 4'b0000;
        expect_load(4'b1100, 32'h4410_0000);
        uf(4'b1000);
        tick();

        // AUDCTL write with an underflow in the same cycle: old AUDCTL governs the reload
        expect_load(4'b0001, 32'h0000_0077);
        underflow = 4'b0001;
        cpu_wr = 1'b1; cpu_addr = 4'h8; cpu_data = 8'h10;
        tick();
        underflow = 4'b0000; cpu_wr = 1'b0;
        tick();

`ifdef POKEY_TIMER_IRQ_EN
        wr(4'hE, 8'h01);
        uf(4'b0001);
        tick();
        chk("irq_pending_set", {29'h0, irq_pending}, 32'h1);
        chk("irq_n_low", {31'h0, irq_n}, 32'h0);
        wr(4'hE, 8'h00);
        tick();
        chk("irq_n_cleared", {31'h0, irq_n}, 32'h1);
`endif

        // Reset mid-run discards a pending reload
        wr(4'h8, 8'h00);
        enable_64 = 1'b1;
        underflow = 4'b0001;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_data", timer_data, 32'h0);
        chk("midrun_reset_audctl", {24'h0, audctl}, 32'h0);
        chk("midrun_reset_enable", {28'h0, timer_enable}, 32'h0);
        tick();
        chk("midrun_reset_wr_en", {28'h0, timer_wr_en}, 32'h0);
        underflow = 4'b0000; enable_64 = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
